// File: rtl/ov7670_sccb_config_seq_if.sv
// Config-ROM read port and SCCB pin bundle for the OV7670 init sequencer.
interface ov7670_sccb_config_seq_if;
    logic [7:0]  rom_addr;
    logic [15:0] rom_dout;
    logic        sioc;
    logic        siod_oe;

    modport master (
        output rom_addr,
        input  rom_dout,
        output sioc,
        output siod_oe
    );

    modport slave (
        input  rom_addr,
        output rom_dout,
        input  sioc,
        input  siod_oe
    );
endinterface

// File: rtl/ov7670_sccb_config_seq.sv
// Walks the OV7670 init ROM and plays each {reg,value} entry out as an
// SCCB 3-phase write; FFF0 entries insert a delay, FFFF ends the sequence.
module ov7670_sccb_config_seq #(
    parameter int         QTR_DIV      = 125,
    parameter int         DELAY_CYCLES = 500000,
    parameter logic [7:0] DEV_ADDR     = 8'h42
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic                            i_start,
    ov7670_sccb_config_seq_if.master        bus,
    output logic                            o_busy,
    output logic                            o_done
);

    localparam int CMAX = (DELAY_CYCLES > QTR_DIV) ? DELAY_CYCLES : QTR_DIV;
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [CW-1:0] QTR_LAST   = CW'(QTR_DIV - 1);
    localparam logic [CW-1:0] DLY_LAST   = CW'(DELAY_CYCLES - 1);
    localparam logic [CW-1:0] FETCH_LAST = CW'(1);
    localparam logic [4:0]    BIT_LAST   = 5'd26;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_START,
        S_BITS,
        S_STOP,
        S_GAP,
        S_DELAY,
        S_NEXT,
        S_DONE
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [1:0]    r_qtr;
    logic [4:0]    r_bit;
    logic [7:0]    r_addr;
    logic [15:0]   r_entry;
    logic          r_sioc;
    logic          r_oe;

    state_t        w_state;
    logic [CW-1:0] w_cnt;
    logic [1:0]    w_qtr;
    logic [4:0]    w_bit;
    logic [7:0]    w_addr;
    logic          w_load;
    logic          w_qend;
    logic [1:0]    w_qlast;
    logic          w_sioc;
    logic          w_oe;
    logic [26:0]   w_frame;
    logic [26:0]   w_shift;

    // Ack slots are sent as 1 so the bus is released for the slave.
    assign w_frame = {DEV_ADDR, 1'b1, r_entry[15:8], 1'b1, r_entry[7:0], 1'b1};
    assign w_qend  = (r_cnt == QTR_LAST);

    always_comb begin
        w_qlast = 2'd3;
        unique case (r_state)
            S_START: w_qlast = 2'd1;
            S_STOP:  w_qlast = 2'd2;
            default: w_qlast = 2'd3;
        endcase
    end

    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_qtr   = r_qtr;
        w_bit   = r_bit;
        w_addr  = r_addr;
        w_load  = 1'b0;

        unique case (r_state)
            S_IDLE, S_DONE: begin
                if (i_start) begin
                    w_state = S_FETCH;
                    w_addr  = 8'd0;
                end
            end
            S_FETCH: begin
                w_cnt = r_cnt + 1'b1;
                if (r_cnt == FETCH_LAST) begin
                    w_state = S_DECODE;
                    w_load  = 1'b1;
                end
            end
            S_DECODE: begin
                if (r_entry == 16'hFFFF)
                    w_state = S_DONE;
                else if (r_entry == 16'hFFF0)
                    w_state = S_DELAY;
                else
                    w_state = S_START;
            end
            S_DELAY: begin
                w_cnt = r_cnt + 1'b1;
                if (r_cnt == DLY_LAST)
                    w_state = S_NEXT;
            end
            S_NEXT: begin
                if (r_addr == 8'hFF) begin
                    w_state = S_DONE;
                end else begin
                    w_addr  = r_addr + 8'd1;
                    w_state = S_FETCH;
                end
            end
            S_START, S_BITS, S_STOP, S_GAP: begin
                w_cnt = r_cnt + 1'b1;
                if (w_qend) begin
                    w_cnt = '0;
                    w_qtr = r_qtr + 2'd1;
                    if (r_qtr == w_qlast) begin
                        unique case (r_state)
                            S_START: w_state = S_BITS;
                            S_BITS: begin
                                if (r_bit == BIT_LAST)
                                    w_state = S_STOP;
                                else
                                    w_bit = r_bit + 5'd1;
                            end
                            S_STOP:  w_state = S_GAP;
                            default: w_state = S_NEXT;
                        endcase
                    end
                end
            end
            default: w_state = S_IDLE;
        endcase

        // Every state starts with fresh quarter/bit/cycle counters.
        if (w_state != r_state) begin
            w_cnt = '0;
            w_qtr = 2'd0;
            w_bit = 5'd0;
        end
    end

    // Pin levels are decoded from the upcoming state so they register in step with it.
    always_comb begin
        w_sioc  = 1'b1;
        w_oe    = 1'b0;
        w_shift = w_frame << w_bit;
        unique case (w_state)
            S_START: w_oe = (w_qtr == 2'd1);
            S_BITS: begin
                w_sioc = w_qtr[1];
                w_oe   = ~w_shift[26];
            end
            S_STOP: begin
                w_sioc = (w_qtr != 2'd0);
                w_oe   = (w_qtr != 2'd2);
            end
            default: begin
                w_sioc = 1'b1;
                w_oe   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_qtr   <= 2'd0;
            r_bit   <= 5'd0;
            r_addr  <= 8'd0;
            r_entry <= 16'd0;
            r_sioc  <= 1'b1;
            r_oe    <= 1'b0;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_qtr   <= w_qtr;
            r_bit   <= w_bit;
            r_addr  <= w_addr;
            r_sioc  <= w_sioc;
            r_oe    <= w_oe;
            if (w_load)
                r_entry <= bus.rom_dout;
        end
    end

    assign bus.rom_addr = r_addr;
    assign bus.sioc     = r_sioc;
    assign bus.siod_oe  = r_oe;
    assign o_busy       = (r_state != S_IDLE) && (r_state != S_DONE);
    assign o_done       = (r_state == S_DONE);

endmodule
